// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST sequencer: FSM states,
// expected truth tables of the supported library cells and the MISR polynomial.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } bist_state_e;

  // Truth tables indexed by input vector; vec[N_IN-1] is the first cell input.
  localparam logic [15:0] TT_OAI22 = 16'h111F;
  localparam logic [15:0] TT_AOI22 = 16'h0777;
  localparam logic [3:0]  TT_NAND2 = 4'b0111;
  localparam logic [3:0]  TT_NOR2  = 4'b0001;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] MISR_POLY = 16'h1021;

endpackage

// File: rtl/gate_bist_misr.sv
// 16-bit multiple-input signature register over the sampled {dut_y, dut_vec}.
// Only instantiated when GATE_BIST_SIG_EN is defined.
module gate_bist_misr
  import gate_bist_pkg::*;
#(
  parameter int W_IN = 5
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            clr,
  input  logic            en,
  input  logic [W_IN-1:0] data,
  output logic [15:0]     sig
);

  logic [15:0] shifted;

  assign shifted = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : '0);

  always_ff @(posedge CLK) begin
    if (!RN) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= shifted ^ 16'(data);
    end
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// Exhaustive BIST sequencer for one combinational cell: drives every input
// vector, samples after a settle time, and compares against EXP_TT.
// Optional signature output enabled by GATE_BIST_SIG_EN.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int          N_IN   = 4,
  parameter int          SETTLE = 2,
  parameter logic [63:0] EXP_TT = 64'(TT_OAI22)
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] dut_vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail
`ifdef GATE_BIST_SIG_EN
  ,
  output logic [15:0]     sig
`endif
);

  localparam int              NV          = 1 << N_IN;
  localparam logic [NV-1:0]   TT          = EXP_TT[NV-1:0];
  localparam logic [3:0]      SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;

  bist_state_e state, state_nxt;
  logic [3:0]  settle_cnt;
  logic        first_seen;
  logic        mismatch;
  logic        last_vec;
  logic        settle_end;

  assign mismatch   = (dut_y != TT[dut_vec]);
  assign last_vec   = (dut_vec == VEC_LAST);
  assign settle_end = (settle_cnt == SETTLE_LAST);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (SETTLE == 0) ? SAMPLE : WAIT;
      WAIT:    if (settle_end) state_nxt = SAMPLE;
      SAMPLE: begin
        if (last_vec)         state_nxt = DONE;
        else if (SETTLE == 0) state_nxt = SAMPLE;
        else                  state_nxt = WAIT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state      <= IDLE;
      dut_vec    <= '0;
      pass       <= 1'b0;
      fail_count <= '0;
      first_fail <= '0;
      first_seen <= 1'b0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          dut_vec    <= '0;
          settle_cnt <= '0;
          if (start) begin
            pass       <= 1'b0;
            fail_count <= '0;
            first_fail <= '0;
            first_seen <= 1'b0;
          end
        end
        WAIT: settle_cnt <= settle_end ? 4'd0 : settle_cnt + 4'd1;
        SAMPLE: begin
          if (mismatch) begin
            fail_count <= fail_count + 1'b1;
            if (!first_seen) begin
              first_fail <= dut_vec;
              first_seen <= 1'b1;
            end
          end
          // pass is resolved here so it is already valid while done is high
          if (last_vec) begin
            pass    <= (fail_count == '0) && !mismatch;
            dut_vec <= '0;
          end else begin
            dut_vec <= dut_vec + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_BIST_SIG_EN
  gate_bist_misr #(
    .W_IN(N_IN + 1)
  ) u_misr (
    .CLK  (CLK),
    .RN   (RN),
    .clr  ((state == IDLE) && start),
    .en   (state == SAMPLE),
    .data ({dut_y, dut_vec}),
    .sig  (sig)
  );
`endif

endmodule
